// File: rtl/perm_comb_seq.sv
// perm_comb_seq
//   Multi-cycle sequencer computing nPr or nCr for 8-bit n and r.
//   One shared WIDTH x 8 multiplier and a restoring divider (one quotient
//   bit per cycle) build the result iteratively. Every intermediate value
//   is a permutation or combination count no larger than the final one.
//   An overflowing intermediate therefore means the final result
//   overflows as well.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start_i   in   request, sampled only in IDLE or DONE
//   mode_i    in   0 = nPr, 1 = nCr (latched with start)
//   n_i       in   total items (latched with start)
//   r_i       in   items chosen (latched with start)
//   busy_o    out  high in LOAD, MUL, DIV
//   done_o    out  single-cycle pulse while in DONE
//   result_o  out  final value, held until the next accepted start
//   ovf_o     out  true result exceeds 2^WIDTH-1 (result all-ones)
//   err_o     out  r > n (result zero)
module perm_comb_seq #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [7:0]       n_i,
  input  logic [7:0]       r_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             ovf_o,
  output logic             err_o
);

  localparam int PW = WIDTH + 8;          // product / dividend width
  localparam int CW = $clog2(PW + 1);     // division bit counter width

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q;
  logic               mode_q;
  logic [7:0]         n_q;
  logic [7:0]         r_q;
  logic [7:0]         reff_q;
  logic [7:0]         k_q;
  logic [WIDTH-1:0]   acc_q;
  logic [PW-1:0]      quo_q;      // dividend shifted out MSB-first, quotient shifted in
  logic [7:0]         rem_q;
  logic [7:0]         divisor_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               ovf_q;
  logic               err_q;
  logic               busy_q;
  logic               done_q;

  logic [7:0]         nmr_s;
  logic [7:0]         reff_s;
  logic [7:0]         nk_s;
  logic [7:0]         k_inc_s;
  logic [PW-1:0]      prod_s;
  logic [8:0]         shifted_s;
  logic [8:0]         sub_s;
  logic               ge_s;
  logic [7:0]         rem_next_s;
  logic [PW-1:0]      quo_fin_s;

  // Datapath helpers: effective r, shared multiplier and one divider step.
  always_comb begin
    nmr_s      = n_q - r_q;
    reff_s     = r_q;
    nk_s       = n_q - k_q;
    k_inc_s    = k_q + 8'd1;
    prod_s     = {8'd0, acc_q} * {{WIDTH{1'b0}}, nk_s};
    shifted_s  = {rem_q, quo_q[PW-1]};
    sub_s      = shifted_s - {1'b0, divisor_q};
    ge_s       = (shifted_s >= {1'b0, divisor_q});
    rem_next_s = 8'd0;
    quo_fin_s  = {quo_q[PW-2:0], ge_s};
    if (mode_q && (nmr_s < r_q)) begin
      reff_s = nmr_s;                      // C(n,r) = C(n,n-r): fewer iterations
    end else begin
      reff_s = r_q;
    end
    // Remainder stays below divisor (<=128), so 8 bits always suffice.
    if (ge_s) begin
      rem_next_s = sub_s[7:0];
    end else begin
      rem_next_s = shifted_s[7:0];
    end
  end

  // Sequencer: state, operands, accumulator, divider and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      n_q       <= 8'd0;
      r_q       <= 8'd0;
      reff_q    <= 8'd0;
      k_q       <= 8'd0;
      acc_q     <= {WIDTH{1'b0}};
      quo_q     <= {PW{1'b0}};
      rem_q     <= 8'd0;
      divisor_q <= 8'd0;
      cnt_q     <= {CW{1'b0}};
      result_q  <= {WIDTH{1'b0}};
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_q   <= mode_i;
            n_q      <= n_i;
            r_q      <= r_i;
            result_q <= {WIDTH{1'b0}};
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            state_q  <= S_LOAD;
          end else begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end

        S_LOAD: begin
          acc_q  <= {{(WIDTH-1){1'b0}}, 1'b1};
          k_q    <= 8'd0;
          reff_q <= reff_s;
          if (r_q > n_q) begin
            err_q    <= 1'b1;
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else if (reff_s == 8'd0) begin
            result_q <= {{(WIDTH-1){1'b0}}, 1'b1};
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q  <= S_MUL;
          end
        end

        S_MUL: begin
          if (mode_q) begin
            // nCr: acc*(n-k) is exactly C(n,k+1)*(k+1); divide by k+1 next.
            quo_q     <= prod_s;
            rem_q     <= 8'd0;
            divisor_q <= k_inc_s;
            cnt_q     <= {CW{1'b0}};
            state_q   <= S_DIV;
          end else if (prod_s[PW-1:WIDTH] != 8'd0) begin
            ovf_q    <= 1'b1;
            result_q <= {WIDTH{1'b1}};
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            acc_q <= prod_s[WIDTH-1:0];
            k_q   <= k_inc_s;
            if (k_inc_s == reff_q) begin
              result_q <= prod_s[WIDTH-1:0];
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_MUL;
            end
          end
        end

        S_DIV: begin
          rem_q <= rem_next_s;
          quo_q <= quo_fin_s;
          cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_q == CW'(PW - 1)) begin
            if (quo_fin_s[PW-1:WIDTH] != 8'd0) begin
              ovf_q    <= 1'b1;
              result_q <= {WIDTH{1'b1}};
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              acc_q <= quo_fin_s[WIDTH-1:0];
              k_q   <= k_inc_s;
              if (k_inc_s == reff_q) begin
                result_q <= quo_fin_s[WIDTH-1:0];
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= S_DONE;
              end else begin
                state_q  <= S_MUL;
              end
            end
          end else begin
            state_q <= S_DIV;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign ovf_o    = ovf_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_perm_comb_seq.sv
// tb_perm_comb_seq
//   Directed self-checking bench for perm_comb_seq (WIDTH = 12).
//   Expected results, flags and latencies are hand-computed constants.
module tb_perm_comb_seq;

  localparam int W = 12;

  logic         clk;
  logic         rst_n;
  logic         start_i;
  logic         mode_i;
  logic [7:0]   n_i;
  logic [7:0]   r_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] result_o;
  logic         ovf_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  perm_comb_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .n_i      (n_i),
    .r_i      (r_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .ovf_o    (ovf_o),
    .err_o    (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start (caller sits 1 time unit after a rising edge), then count
  // edges until done; busy_lo counts samples before done with busy low.
  task automatic run_op(input logic m, input logic [7:0] nn, input logic [7:0] rr,
                        output int lat, output int busy_lo);
    start_i = 1'b1; mode_i = m; n_i = nn; r_i = rr;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 0; busy_lo = 0;
    while (done_o !== 1'b1 && lat < 2000) begin
      if (busy_o !== 1'b1) busy_lo++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; n_i = 8'd0; r_i = 8'd0;
    #1;
    checks++;
    if ({busy_o, done_o, result_o, ovf_o, err_o} !== {1'b0, 1'b0, 12'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%0d ovf=%b err=%b required all zero",
               busy_o, done_o, result_o, ovf_o, err_o);
    end
    #21 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_npr();
    int lat, blo;
    run_op(1'b0, 8'd5, 8'd3, lat, blo);
    checks++; if (lat !== 4) begin errors++; $display("FAIL npr53_latency: got %0d required 4", lat); end
    checks++; if (result_o !== 12'd60) begin errors++; $display("FAIL npr53_result: got %0d required 60", result_o); end
    checks++; if ({ovf_o, err_o} !== 2'b00) begin errors++; $display("FAIL npr53_flags: ovf=%b err=%b required 0 0", ovf_o, err_o); end
    checks++; if (blo !== 0) begin errors++; $display("FAIL npr53_busy: busy low %0d samples before done, required 0", blo); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL npr53_busy_at_done: got %b required 0", busy_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL npr53_done_pulse: got %b required 0", done_o); end
    checks++; if (result_o !== 12'd60) begin errors++; $display("FAIL npr53_hold: got %0d required 60", result_o); end
  endtask

  task automatic test_ncr();
    int lat, blo;
    run_op(1'b1, 8'd10, 8'd3, lat, blo);
    checks++; if (lat !== 64) begin errors++; $display("FAIL ncr10_3_latency: got %0d required 64", lat); end
    checks++; if (result_o !== 12'd120) begin errors++; $display("FAIL ncr10_3_result: got %0d required 120", result_o); end
    @(posedge clk); #1;
    run_op(1'b1, 8'd10, 8'd7, lat, blo);
    checks++; if (lat !== 64) begin errors++; $display("FAIL ncr10_7_latency: got %0d required 64", lat); end
    checks++; if (result_o !== 12'd120) begin errors++; $display("FAIL ncr10_7_result: got %0d required 120", result_o); end
    checks++; if ({ovf_o, err_o} !== 2'b00) begin errors++; $display("FAIL ncr10_7_flags: ovf=%b err=%b required 0 0", ovf_o, err_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf();
    int lat, blo;
    run_op(1'b0, 8'd7, 8'd7, lat, blo);
    checks++; if (lat !== 7) begin errors++; $display("FAIL npr77_latency: got %0d required 7", lat); end
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL npr77_ovf: got %b required 1", ovf_o); end
    checks++; if (result_o !== 12'hFFF) begin errors++; $display("FAIL npr77_result: got %0h required fff", result_o); end
    @(posedge clk); #1;
    run_op(1'b0, 8'd6, 8'd6, lat, blo);
    checks++; if (result_o !== 12'd720) begin errors++; $display("FAIL npr66_result: got %0d required 720", result_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL npr66_ovf: got %b required 0", ovf_o); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL npr66_latency: got %0d required 7", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_edge();
    int lat, blo;
    for (int m = 0; m < 2; m++) begin
      run_op(m[0], 8'd3, 8'd5, lat, blo);
      checks++; if (lat !== 1) begin errors++; $display("FAIL err_latency mode%0d: got %0d required 1", m, lat); end
      checks++; if ({err_o, ovf_o, result_o} !== {1'b1, 1'b0, 12'd0}) begin
        errors++; $display("FAIL err_flags mode%0d: err=%b ovf=%b result=%0d required 1 0 0", m, err_o, ovf_o, result_o);
      end
      @(posedge clk); #1;
    end
    run_op(1'b0, 8'd0, 8'd0, lat, blo);
    checks++; if (result_o !== 12'd1) begin errors++; $display("FAIL n0r0_result: got %0d required 1", result_o); end
    @(posedge clk); #1;
    run_op(1'b1, 8'd200, 8'd200, lat, blo);
    checks++; if (lat !== 1) begin errors++; $display("FAIL ncr200_latency: got %0d required 1", lat); end
    checks++; if (result_o !== 12'd1) begin errors++; $display("FAIL ncr200_result: got %0d required 1", result_o); end
    @(posedge clk); #1;
    run_op(1'b1, 8'd255, 8'd254, lat, blo);
    checks++; if (result_o !== 12'd255) begin errors++; $display("FAIL ncr255_254_result: got %0d required 255", result_o); end
    checks++; if (lat !== 22) begin errors++; $display("FAIL ncr255_254_latency: got %0d required 22", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, blo;
    // Start pulse in MUL with different operands must be ignored.
    start_i = 1'b1; mode_i = 1'b0; n_i = 8'd5; r_i = 8'd3;
    @(posedge clk); #1;                 // LOAD
    start_i = 1'b0;
    @(posedge clk); #1;                 // MUL, k=0
    start_i = 1'b1; mode_i = 1'b1; n_i = 8'd6; r_i = 8'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = 2;
    while (done_o !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL ignore_latency: got %0d required 4", lat); end
    checks++; if (result_o !== 12'd60) begin errors++; $display("FAIL ignore_result: got %0d required 60", result_o); end
    // Start held during DONE: accepted on the DONE edge.
    start_i = 1'b1; mode_i = 1'b1; n_i = 8'd6; r_i = 8'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++; if ({done_o, busy_o} !== 2'b01) begin errors++; $display("FAIL b2b_load: done=%b busy=%b required 0 1", done_o, busy_o); end
    lat = 0;
    while (done_o !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (result_o !== 12'd15) begin errors++; $display("FAIL b2b_result: got %0d required 15", result_o); end
    checks++; if (lat !== 43) begin errors++; $display("FAIL b2b_latency: got %0d required 43", lat); end
    @(posedge clk); #1;
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse: got %b required 0", done_o); end
  endtask

  task automatic test_reset_midop();
    int lat, blo;
    start_i = 1'b1; mode_i = 1'b1; n_i = 8'd10; r_i = 8'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end   // well inside the first DIV
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL midop_busy_before: got %b required 1", busy_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, done_o, result_o, ovf_o, err_o} !== {1'b0, 1'b0, 12'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midop_reset: busy=%b done=%b result=%0d ovf=%b err=%b required all zero",
               busy_o, done_o, result_o, ovf_o, err_o);
    end
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b0, 8'd4, 8'd2, lat, blo);
    checks++; if (result_o !== 12'd12) begin errors++; $display("FAIL after_reset_result: got %0d required 12", result_o); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL after_reset_latency: got %0d required 3", lat); end
  endtask

  initial begin
    test_reset();
    test_npr();
    test_ncr();
    test_ovf();
    test_edge();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
